// File: rtl/dcache_data_array.sv
// One-read/one-write data array for the dcache. Word-granular write enables, write-first
// forwarding on a same-row read, and a hardware sweep to INIT_VALUE after reset or clear.
module dcache_data_array #(
  parameter int WIDTH = 512,
  parameter int LOG_NUM_ROWS = 9,
  parameter int WORD_SIZE = 64,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  output logic                          ready,
  input  logic                          readEn,
  input  logic [LOG_NUM_ROWS-1:0]       readAddr,
  output logic [WIDTH-1:0]              readData,
  output logic                          readValid,
  input  logic [LOG_NUM_ROWS-1:0]       writeAddr,
  input  logic [WIDTH-1:0]              writeData,
  input  logic [WIDTH/WORD_SIZE-1:0]    writeEnable,
  output logic                          debugState
);

  localparam int NUM_ROWS = 2 ** LOG_NUM_ROWS;
  localparam int NUM_WORDS = WIDTH / WORD_SIZE;
  localparam logic [LOG_NUM_ROWS-1:0] LAST_ROW = '1;

  // Handshake: readEn is taken on any edge where ready is high and clear is low;
  // readValid then qualifies readData for exactly one cycle. No back-pressure exists.
  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  state_t                  state;
  logic [LOG_NUM_ROWS-1:0] initRow;
  logic [WIDTH-1:0]        mem [NUM_ROWS];
  logic [WIDTH-1:0]        fwdRow;

  assign debugState = state;

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[initRow] <= INIT_VALUE;
    end else if (!clear) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (writeEnable[i]) begin
          mem[writeAddr][i*WORD_SIZE +: WORD_SIZE] <= writeData[i*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  // Write-first: enabled words of a same-row write override the stored row.
  always_comb begin
    fwdRow = mem[readAddr];
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (writeEnable[i] && (writeAddr == readAddr)) begin
        fwdRow[i*WORD_SIZE +: WORD_SIZE] = writeData[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      initRow   <= '0;
      ready     <= 1'b0;
      readValid <= 1'b0;
      readData  <= '0;
    end else begin
      case (state)
        INIT: begin
          readValid <= 1'b0;
          initRow   <= initRow + 1'b1;
          if (initRow == LAST_ROW) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (clear) begin
            state     <= INIT;
            initRow   <= '0;
            ready     <= 1'b0;
            readValid <= 1'b0;
          end else begin
            readValid <= readEn;
            if (readEn) begin
              readData <= fwdRow;
            end
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule
